// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame parity and cycle-count helpers.
package ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SHIFT,
    S_ACK,
    S_WAITIDLE
  } ps2_state_t;

  localparam int WDOG_W = 20;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  function automatic int cycles_from_us(input int khz, input int us);
    return (khz * us) / 1000;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer plus 4-sample majority filter with hysteresis for one PS/2 line.
// Filtered output lags the raw line by roughly five cycles; idles high out of reset.
module ps2_line_sync (
  input  logic i_sysclk,
  input  logic i_rst,
  input  logic i_line,
  output logic o_filt
);

  logic       r_meta;
  logic       r_sync;
  logic [2:0] r_hist;
  logic       r_filt;
  logic [2:0] w_ones;

  // A 2-2 split keeps the previous level, so a single glitch never toggles the output.
  assign w_ones = 3'(r_sync) + 3'(r_hist[0]) + 3'(r_hist[1]) + 3'(r_hist[2]);

  always_ff @(posedge i_sysclk) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_hist <= 3'b111;
      r_filt <= 1'b1;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
      r_hist <= {r_hist[1:0], r_sync};
      if (w_ones >= 3'd3)
        r_filt <= 1'b1;
      else if (w_ones <= 3'd1)
        r_filt <= 1'b0;
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, device-clocked frame, ACK.
// Define PS2_TX_ACK_CHECK_EN to report a device NACK through tx_error.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLKFREQ_KHZ = 28000,
  parameter int INHIBIT_US  = 120,
  parameter int TIMEOUT_MS  = 20
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_oe,
  output logic       ps2data_oe
);

  localparam int INHIBIT_CYC = cycles_from_us(CLKFREQ_KHZ, INHIBIT_US);
  localparam int TIMEOUT_CYC = cycles_from_us(CLKFREQ_KHZ, TIMEOUT_MS * 1000);
  localparam int CNT_W       = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;

  ps2_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [WDOG_W-1:0] r_wdog;
  logic              r_wd_on;
  logic [3:0]        r_idx;
  logic [8:0]        r_shift;
  logic              r_clk_oe;
  logic              r_data_oe;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_clk_prev;
`ifdef PS2_TX_ACK_CHECK_EN
  logic              r_nack;
`endif

  logic w_clk_filt;
  logic w_data_filt;
  logic w_fe;
  logic w_wd_fire;

  ps2_line_sync u_clk_sync (
    .i_sysclk (sysclk),
    .i_rst    (rst),
    .i_line   (ps2clk_in),
    .o_filt   (w_clk_filt)
  );

  ps2_line_sync u_data_sync (
    .i_sysclk (sysclk),
    .i_rst    (rst),
    .i_line   (ps2data_in),
    .o_filt   (w_data_filt)
  );

  assign w_fe      = r_clk_prev & ~w_clk_filt;
  assign w_wd_fire = r_wd_on && (r_wdog == WDOG_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge sysclk) begin
    r_clk_prev <= w_clk_filt;
    r_done     <= 1'b0;
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_wdog     <= '0;
      r_wd_on    <= 1'b0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_clk_prev <= 1'b1;
`ifdef PS2_TX_ACK_CHECK_EN
      r_nack     <= 1'b0;
`endif
    end else if (w_wd_fire) begin
      r_state   <= S_IDLE;
      r_wd_on   <= 1'b0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b1;
      r_err     <= 1'b1;
    end else begin
      if (r_wd_on)
        r_wdog <= r_wdog + WDOG_W'(1);
      case (r_state)
        S_IDLE: begin
          // A start landing on the done pulse belongs to the finished transfer and is dropped.
          if (tx_start && !r_done) begin
            r_shift  <= {odd_parity(tx_data), tx_data};
            r_cnt    <= '0;
            r_clk_oe <= 1'b1;
            r_busy   <= 1'b1;
            r_err    <= 1'b0;
            r_state  <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (r_cnt == CNT_W'(INHIBIT_CYC - 1)) begin
            r_data_oe <= 1'b1;
            r_wdog    <= '0;
            r_wd_on   <= 1'b1;
            r_state   <= S_RTS;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RTS: begin
          r_clk_oe <= 1'b0;
          r_idx    <= '0;
          r_state  <= S_SHIFT;
        end
        S_SHIFT: begin
          // Ones shift in behind the data so the tenth edge releases the line as the stop bit.
          if (w_fe) begin
            r_data_oe <= ~r_shift[0];
            r_shift   <= {1'b1, r_shift[8:1]};
            r_idx     <= r_idx + 4'd1;
            if (r_idx == 4'd9)
              r_state <= S_ACK;
          end
        end
        S_ACK: begin
          if (w_fe) begin
`ifdef PS2_TX_ACK_CHECK_EN
            r_nack  <= w_data_filt;
`endif
            r_state <= S_WAITIDLE;
          end
        end
        S_WAITIDLE: begin
          if (w_clk_filt && w_data_filt) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_wd_on <= 1'b0;
            r_state <= S_IDLE;
`ifdef PS2_TX_ACK_CHECK_EN
            r_err   <= r_nack;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_busy    = r_busy;
  assign tx_done    = r_done;
  assign tx_error   = r_err;
  assign ps2clk_oe  = r_clk_oe;
  assign ps2data_oe = r_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model, behavioural PS/2 device and frame reference model.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  // Scaled clock so one sysclk cycle is 1 us and the watchdog stays short.
  localparam int KHZ     = 1000;
  localparam int INH_US  = 120;
  localparam int TO_MS   = 4;
  localparam int INH_CYC = KHZ * INH_US / 1000;
  localparam int TO_CYC  = KHZ * TO_MS;
  localparam int HALF    = 40;

  logic       sysclk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_error, ps2clk_oe, ps2data_oe;
  logic       ps2clk_in, ps2data_in;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  bit         dev_abort = 1'b0;
  int         dev_fe = 0;

  int passed = 0;
  int total  = 0;

  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [1:0] oe_at_done = 2'b00;
  int clk_run = 0;
  int last_clk_run = 0;
  int data_rise_cyc = -1;

  logic [10:0] x_bits;
  logic        x_err, x_busy1, x_clk1, x_sod_busy, x_sod_clk;
  int          x_ndone;

  assign ps2clk_in  = ~(ps2clk_oe | dev_clk_low);
  assign ps2data_in = ~(ps2data_oe | dev_data_low);

  ps2_host_tx #(
    .CLKFREQ_KHZ (KHZ),
    .INHIBIT_US  (INH_US),
    .TIMEOUT_MS  (TO_MS)
  ) dut (
    .sysclk     (sysclk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .ps2clk_in  (ps2clk_in),
    .ps2data_in (ps2data_in),
    .ps2clk_oe  (ps2clk_oe),
    .ps2data_oe (ps2data_oe)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) begin
    cyc++;
    #1;
    if (tx_done) begin
      done_cnt++;
      done_cyc   = cyc;
      oe_at_done = {ps2clk_oe, ps2data_oe};
    end
    if (ps2clk_oe) clk_run++;
    else if (clk_run != 0) begin
      last_clk_run = clk_run;
      clk_run = 0;
    end
    if (ps2data_oe && data_rise_cyc < 0) data_rise_cyc = cyc;
  end

  // Reference frame: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = (($countones(d) % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  function automatic logic exp_nack_err(input bit ack);
`ifdef PS2_TX_ACK_CHECK_EN
    return !ack;
`else
    return 1'b0;
`endif
  endfunction

  // Device side: waits for request-to-send, clocks 11 bits sampling late in each high phase.
  task automatic device(input bit ack, input bit hang);
    int t;
    t = 0;
    while (!(ps2clk_in && !ps2data_in) && t < INH_CYC + 500) begin
      @(negedge sysclk);
      t++;
    end
    if (ps2clk_in && !ps2data_in) begin
      for (int k = 0; k < 11; k++) begin
        if (dev_abort) break;
        repeat (HALF) @(negedge sysclk);
        x_bits[k] = ps2data_in;
        if (k == 10 && ack) begin
          dev_data_low = 1'b1;
          repeat (5) @(negedge sysclk);
        end
        dev_clk_low = 1'b1;
        dev_fe = k + 1;
        repeat (HALF) @(negedge sysclk);
        dev_clk_low = 1'b0;
      end
      if (!dev_abort) begin
        repeat (HALF) @(negedge sysclk);
        if (!hang) dev_data_low = 1'b0;
      end
    end
  endtask

  task automatic do_xfer(input logic [7:0] d, input bit use_dev, input bit ack,
                         input bit hang, input bit poke, input bit sod);
    int t0;
    last_clk_run  = 0;
    data_rise_cyc = -1;
    dev_fe = 0;
    x_bits = '1;
    t0 = done_cnt;
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge sysclk);
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
    x_busy1  = tx_busy;
    x_clk1   = ps2clk_oe;
    fork
      begin
        if (use_dev) device(ack, hang);
      end
      begin
        if (poke) begin
          repeat (INH_CYC + 400) @(negedge sysclk);
          tx_data  = 8'h00;
          tx_start = 1'b1;
          @(negedge sysclk);
          tx_start = 1'b0;
        end
      end
      begin : waiter
        int w;
        w = 0;
        while (done_cnt == t0 && w < INH_CYC + TO_CYC + 300) begin
          @(negedge sysclk);
          w++;
        end
        x_err = tx_error;
        if (sod && done_cnt != t0) begin
          tx_data  = 8'hAA;
          tx_start = 1'b1;
          @(negedge sysclk);
          tx_start   = 1'b0;
          x_sod_busy = tx_busy;
          x_sod_clk  = ps2clk_oe;
        end
      end
    join
    repeat (60) @(negedge sysclk);
    x_ndone = done_cnt - t0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tx_start = 1'b1;
    tx_data = 8'hED;
    repeat (4) @(negedge sysclk);
    total++; if (tx_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", tx_busy); else passed++;
    total++; if (tx_done !== 1'b0) $display("FAIL reset_done: got %b want 0", tx_done); else passed++;
    total++; if (tx_error !== 1'b0) $display("FAIL reset_error: got %b want 0", tx_error); else passed++;
    total++; if (ps2clk_oe !== 1'b0) $display("FAIL reset_clk_oe: got %b want 0", ps2clk_oe); else passed++;
    total++; if (ps2data_oe !== 1'b0) $display("FAIL reset_data_oe: got %b want 0", ps2data_oe); else passed++;
    rst = 1'b0;
    tx_start = 1'b0;
    repeat (10) @(negedge sysclk);
  endtask

  task automatic test_send(input logic [7:0] d, input string nm);
    do_xfer(d, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (x_busy1 !== 1'b1) $display("FAIL %s_busy_next: got %b want 1", nm, x_busy1); else passed++;
    total++; if (x_clk1 !== 1'b1) $display("FAIL %s_clk_oe_next: got %b want 1", nm, x_clk1); else passed++;
    total++; if (last_clk_run != INH_CYC + 1) $display("FAIL %s_inhibit_len: got %0d want %0d", nm, last_clk_run, INH_CYC + 1); else passed++;
    total++; if (x_bits !== frame_of(d)) $display("FAIL %s_frame: got %b want %b", nm, x_bits, frame_of(d)); else passed++;
    total++; if (x_ndone != 1) $display("FAIL %s_done_count: got %0d want 1", nm, x_ndone); else passed++;
    total++; if (x_err !== 1'b0) $display("FAIL %s_error: got %b want 0", nm, x_err); else passed++;
    total++; if (tx_busy !== 1'b0) $display("FAIL %s_busy_after: got %b want 0", nm, tx_busy); else passed++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 5; n++) begin
      logic [7:0] d;
      bit ack;
      d   = 8'($urandom);
      ack = bit'($urandom_range(0, 1));
      do_xfer(d, 1'b1, ack, 1'b0, 1'b0, 1'b0);
      total++; if (x_bits !== frame_of(d)) $display("FAIL rand_frame %h: got %b want %b", d, x_bits, frame_of(d)); else passed++;
      total++; if (x_err !== exp_nack_err(ack)) $display("FAIL rand_error %h ack=%0d: got %b want %b", d, ack, x_err, exp_nack_err(ack)); else passed++;
      total++; if (x_ndone != 1) $display("FAIL rand_done %h: got %0d want 1", d, x_ndone); else passed++;
    end
  endtask

  task automatic test_nack();
    do_xfer(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (x_err !== exp_nack_err(1'b0)) $display("FAIL nack_error: got %b want %b", x_err, exp_nack_err(1'b0)); else passed++;
    total++; if (x_ndone != 1) $display("FAIL nack_done: got %0d want 1", x_ndone); else passed++;
  endtask

  task automatic test_timeout(input bit in_waitidle, input string nm);
    do_xfer(8'h5A, in_waitidle, 1'b1, in_waitidle, 1'b0, 1'b0);
    total++; if (x_ndone != 1) $display("FAIL %s_done: got %0d want 1", nm, x_ndone); else passed++;
    total++; if (x_err !== 1'b1) $display("FAIL %s_error: got %b want 1", nm, x_err); else passed++;
    total++; if (oe_at_done !== 2'b00) $display("FAIL %s_oe_released: got %b want 00", nm, oe_at_done); else passed++;
    total++; if (done_cyc - data_rise_cyc != TO_CYC) $display("FAIL %s_delay: got %0d want %0d", nm, done_cyc - data_rise_cyc, TO_CYC); else passed++;
    dev_data_low = 1'b0;
    repeat (20) @(negedge sysclk);
  endtask

  task automatic test_reset_mid();
    int   t0;
    logic [1:0] oe_after;
    logic busy_after;
    t0 = done_cnt;
    dev_fe = 0;
    dev_abort = 1'b0;
    tx_data  = 8'hED;
    tx_start = 1'b1;
    @(negedge sysclk);
    tx_start = 1'b0;
    fork
      device(1'b1, 1'b0);
      begin : rstr
        int w;
        w = 0;
        while (dev_fe < 6 && w < 3000) begin
          @(negedge sysclk);
          w++;
        end
        repeat (10) @(negedge sysclk);
        rst = 1'b1;
        @(negedge sysclk);
        oe_after   = {ps2clk_oe, ps2data_oe};
        busy_after = tx_busy;
        rst = 1'b0;
        dev_abort = 1'b1;
      end
    join
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    dev_abort    = 1'b0;
    repeat (300) @(negedge sysclk);
    total++; if (oe_after !== 2'b00) $display("FAIL midrst_oe: got %b want 00", oe_after); else passed++;
    total++; if (busy_after !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy_after); else passed++;
    total++; if (done_cnt != t0) $display("FAIL midrst_no_done: got %0d want 0", done_cnt - t0); else passed++;
    test_send(8'hF4, "after_rst");
  endtask

  task automatic test_ignore_start();
    do_xfer(8'hED, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    total++; if (x_bits !== frame_of(8'hED)) $display("FAIL ignore_frame: got %b want %b", x_bits, frame_of(8'hED)); else passed++;
    total++; if (x_ndone != 1) $display("FAIL ignore_done: got %0d want 1", x_ndone); else passed++;
    total++; if (x_err !== 1'b0) $display("FAIL ignore_error: got %b want 0", x_err); else passed++;
  endtask

  task automatic test_back_to_back();
    x_sod_busy = 1'bx;
    x_sod_clk  = 1'bx;
    do_xfer(8'hF4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    total++; if (x_sod_busy !== 1'b0) $display("FAIL b2b_busy: got %b want 0", x_sod_busy); else passed++;
    total++; if (x_sod_clk !== 1'b0) $display("FAIL b2b_clk_oe: got %b want 0", x_sod_clk); else passed++;
    total++; if (x_ndone != 1) $display("FAIL b2b_done: got %0d want 1", x_ndone); else passed++;
  endtask

  initial begin
    test_reset();
    test_send(8'hED, "ed");
    test_send(8'hF4, "f4");
    test_random();
    test_nack();
    test_timeout(1'b0, "timeout");
    test_timeout(1'b1, "wd_waitidle");
    test_reset_mid();
    test_ignore_start();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
